imm_gen_stage: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage of the RISC-V core. It accepts one instruction word per cycle over a valid/ready handshake and produces the sign-extended immediate, the instruction format code and an illegal-opcode flag one cycle later. It is generalised to XLEN = 32 or 64, covers every base-ISA immediate format, and contains a two-entry skid buffer so the fetch-to-decode path is fully registered under backpressure.

---
 rtl/imm_gen_stage.sv | 245 ++++++++++++++++++++++++
 tb/tb_imm_gen_stage.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: decodes the RISC-V immediate, format code and
// illegal-opcode flag, registered behind a two-entry skid buffer (main + skid).
module imm_gen_stage #(
  parameter int XLEN = 32,
  parameter int TAGW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [31:0]     out_instr,
  output logic [TAGW-1:0] out_tag
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_ZIMM  = 3'd7;

  typedef enum logic [1:0] {
    IMM_ZERO,
    IMM_SEXT,
    IMM_ZEXT
  } imm_kind_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [31:0]     instr;
    logic [TAGW-1:0] tag;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Immediate decode
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [31:0]     sext_raw;
  logic [5:0]      zext_raw;
  imm_kind_e       imm_kind;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_imm;
  entry_t          dec_entry;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    sext_raw    = '0;
    zext_raw    = '0;
    imm_kind    = IMM_ZERO;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec_fmt  = FMT_U;
        imm_kind = IMM_SEXT;
        sext_raw = {in_instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        dec_fmt  = FMT_J;
        imm_kind = IMM_SEXT;
        sext_raw = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD: begin
        dec_fmt  = FMT_I;
        imm_kind = IMM_SEXT;
        sext_raw = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_OP_IMM: begin
        if (is_shift) begin
          // Bit 30 selects SRAI and is never part of the shift amount.
          dec_fmt  = FMT_SHAMT;
          imm_kind = IMM_ZEXT;
          zext_raw = {(XLEN == 64) ? in_instr[25] : 1'b0, in_instr[24:20]};
        end else begin
          dec_fmt  = FMT_I;
          imm_kind = IMM_SEXT;
          sext_raw = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      OPC_OP_IMM_32: begin
        if (XLEN != 64) begin
          dec_illegal = 1'b1;
        end else if (is_shift) begin
          dec_fmt  = FMT_SHAMT;
          imm_kind = IMM_ZEXT;
          zext_raw = {1'b0, in_instr[24:20]};
        end else begin
          dec_fmt  = FMT_I;
          imm_kind = IMM_SEXT;
          sext_raw = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      OPC_STORE: begin
        dec_fmt  = FMT_S;
        imm_kind = IMM_SEXT;
        sext_raw = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OPC_BRANCH: begin
        dec_fmt  = FMT_B;
        imm_kind = IMM_SEXT;
        sext_raw = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
      end
      OPC_SYSTEM: begin
        if (funct3[2]) begin
          dec_fmt  = FMT_ZIMM;
          imm_kind = IMM_ZEXT;
          zext_raw = {1'b0, in_instr[19:15]};
        end
      end
      OPC_OP, OPC_MISC_MEM: begin
        dec_fmt = FMT_NONE;
      end
      OPC_OP_32: begin
        dec_illegal = (XLEN != 64);
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    dec_imm = '0;
    case (imm_kind)
      IMM_SEXT: dec_imm = XLEN'($signed(sext_raw));
      IMM_ZEXT: dec_imm = XLEN'(zext_raw);
      default:  dec_imm = '0;
    endcase
  end

  always_comb begin
    dec_entry         = '0;
    dec_entry.imm     = dec_imm;
    dec_entry.fmt     = dec_fmt;
    dec_entry.illegal = dec_illegal;
    dec_entry.instr   = in_instr;
    dec_entry.tag     = in_tag;
  end

  // ---------------------------------------------------------------------------
  // Skid buffer. Valid/ready: a beat moves on a rising edge where valid and
  // ready are both high; a producer holds valid and payload until it moves.
  // in_ready looks only at the skid slot, never at out_ready.
  // ---------------------------------------------------------------------------
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_xfer;
  logic   out_xfer;

  assign in_ready = !skid_valid_q && !rst;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_valid_q && out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (out_xfer) begin
        if (skid_valid_q) begin
          main_d       = skid_q;
          skid_valid_d = 1'b0;
        end else begin
          main_valid_d = 1'b0;
        end
      end
      // in_xfer implies the skid slot is empty, so it never collides with the move above.
      if (in_xfer) begin
        if (!main_valid_q || out_xfer) begin
          main_d       = dec_entry;
          main_valid_d = 1'b1;
        end else begin
          skid_d       = dec_entry;
          skid_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign out_instr   = main_q.instr;
  assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share one input stream;
// expected entries are queued on input transfer and compared on output transfer.
module tb_imm_gen_stage;
  localparam int EW = 32 + 32 + 3 + 1 + 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_tag = '0;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_instr32, out_tag32;
  logic [2:0]  out_fmt32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_instr64, out_tag64;
  logic [2:0]  out_fmt64;

  logic [EW-1:0] got32, got64;
  logic [EW-1:0] exp32_q[$];
  logic [EW-1:0] exp64_q[$];
  logic [EW-1:0] cur_exp32 = '0, cur_exp64 = '0;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imm_gen_stage #(.XLEN(32), .TAGW(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_instr(out_instr32),
    .out_tag(out_tag32)
  );

  imm_gen_stage #(.XLEN(64), .TAGW(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_instr(out_instr64),
    .out_tag(out_tag64)
  );

  assign got32 = {out_tag32, out_instr32, out_fmt32, out_illegal32, 32'b0, out_imm32};
  assign got64 = {out_tag64, out_instr64, out_fmt64, out_illegal64, out_imm64};

  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference decode written from the ISA field layouts.
  function automatic logic [EW-1:0] model(input logic [31:0] i, input logic [31:0] tag,
                                          input bit is64);
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    imm = '0;
    fmt = 3'd0;
    ill = 1'b0;
    case (i[6:0])
      7'h37, 7'h17: begin fmt = 3'd4; imm = 64'($signed({i[31:12], 12'h000})); end
      7'h6F: begin fmt = 3'd5; imm = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
      7'h67, 7'h03: begin fmt = 3'd1; imm = 64'($signed(i[31:20])); end
      7'h13: begin
        if (i[13:12] == 2'b01) begin
          fmt = 3'd6;
          imm = is64 ? {58'b0, i[25:20]} : {59'b0, i[24:20]};
        end else begin
          fmt = 3'd1; imm = 64'($signed(i[31:20]));
        end
      end
      7'h1B: begin
        if (!is64) ill = 1'b1;
        else if (i[13:12] == 2'b01) begin fmt = 3'd6; imm = {59'b0, i[24:20]}; end
        else begin fmt = 3'd1; imm = 64'($signed(i[31:20])); end
      end
      7'h23: begin fmt = 3'd2; imm = 64'($signed({i[31:25], i[11:7]})); end
      7'h63: begin fmt = 3'd3; imm = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
      7'h73: if (i[14]) begin fmt = 3'd7; imm = {59'b0, i[19:15]}; end
      7'h33, 7'h0F: ill = 1'b0;
      7'h3B: ill = !is64;
      default: ill = 1'b1;
    endcase
    if (!is64) imm = {32'b0, imm[31:0]};
    return {tag, i, fmt, ill, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops[16];
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h1B, 7'h23,
            7'h63, 7'h73, 7'h33, 7'h3B, 7'h0F, 7'h7F, 7'h00, 7'h5B};
    w = $urandom();
    w[6:0] = ops[$urandom_range(0, 15)];
    return w;
  endfunction

  // Monitor: pop on output transfer, push on input transfer, drop on flush/reset.
  always @(negedge clk) begin
    if (rst) begin
      exp32_q.delete();
      exp64_q.delete();
    end else begin
      if (out_ready && !flush) begin
        if (out_valid32) begin
          if (exp32_q.size() == 0) check("spurious32", EW'(out_valid32), EW'(0));
          else check("out32", got32, exp32_q.pop_front());
        end
        if (out_valid64) begin
          if (exp64_q.size() == 0) check("spurious64", EW'(out_valid64), EW'(0));
          else check("out64", got64, exp64_q.pop_front());
        end
      end
      if (flush) begin
        exp32_q.delete();
        exp64_q.delete();
      end else if (in_valid && in_ready32) begin
        exp32_q.push_back(cur_exp32);
        exp64_q.push_back(cur_exp64);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input logic [31:0] instr, input logic [31:0] tag,
                         input logic [EW-1:0] e32, input logic [EW-1:0] e64);
    in_instr  = instr;
    in_tag    = tag;
    cur_exp32 = e32;
    cur_exp64 = e64;
  endtask

  task automatic set_rand(input logic [31:0] tag);
    logic [31:0] w;
    w = rand_instr();
    set_vec(w, tag, model(w, tag, 1'b0), model(w, tag, 1'b1));
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] tag,
                      input logic [EW-1:0] e32, input logic [EW-1:0] e64, input bit rand_bp);
    logic acc;
    acc = 1'b0;
    set_vec(instr, tag, e32, e64);
    in_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_ready32;
      step();
      if (acc) break;
    end
    if (!acc) check("send_timeout", EW'(acc), EW'(1));
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [31:0] tag, input bit rand_bp);
    logic [31:0] w;
    w = rand_instr();
    send(w, tag, model(w, tag, 1'b0), model(w, tag, 1'b1), rand_bp);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (exp32_q.size() == 0 && exp64_q.size() == 0) break;
      step();
    end
    check({tag, "_q32"}, EW'(exp32_q.size()), EW'(0));
    check({tag, "_q64"}, EW'(exp64_q.size()), EW'(0));
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [2:0]  f32;
    logic        i32;
    logic [63:0] imm64;
    logic [2:0]  f64;
    logic        i64;
  } dvec_t;

  dvec_t dtab[14];

  initial begin
    int c0;
    int t;
    logic acc;
    dtab[0]  = '{32'h800000B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
    dtab[1]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    dtab[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
    dtab[3]  = '{32'h800000EF, 32'hFFF00000, 3'd5, 1'b0, 64'hFFFFFFFFFFF00000, 3'd5, 1'b0};
    dtab[4]  = '{32'h4010D093, 32'h00000001, 3'd6, 1'b0, 64'h1, 3'd6, 1'b0};
    dtab[5]  = '{32'h03F09093, 32'h0000001F, 3'd6, 1'b0, 64'h3F, 3'd6, 1'b0};
    dtab[6]  = '{32'hFFF0809B, 32'h00000000, 3'd0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    dtab[7]  = '{32'h0000007F, 32'h00000000, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1};
    dtab[8]  = '{32'h3401D073, 32'h00000003, 3'd7, 1'b0, 64'h3, 3'd7, 1'b0};
    dtab[9]  = '{32'h0210D09B, 32'h00000000, 3'd0, 1'b1, 64'h1, 3'd6, 1'b0};
    dtab[10] = '{32'h0000003B, 32'h00000000, 3'd0, 1'b1, 64'h0, 3'd0, 1'b0};
    dtab[11] = '{32'h12345017, 32'h12345000, 3'd4, 1'b0, 64'h12345000, 3'd4, 1'b0};
    dtab[12] = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
    dtab[13] = '{32'h00000073, 32'h00000000, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0};

    // Reset values
    repeat (2) step();
    @(negedge clk);
    check("rst_out32", got32, '0);
    check("rst_out64", got64, '0);
    check("rst_rdy32", EW'(in_ready32), EW'(0));
    check("rst_rdy64", EW'(in_ready64), EW'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", EW'(in_ready32), EW'(1));
    step();

    // Directed vectors, back to back with the consumer always ready
    out_ready = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 14; k++) begin
      send(dtab[k].instr, 32'(100 + k),
           {32'(100 + k), dtab[k].instr, dtab[k].f32, dtab[k].i32, 32'b0, dtab[k].imm32},
           {32'(100 + k), dtab[k].instr, dtab[k].f64, dtab[k].i64, dtab[k].imm64}, 1'b0);
      if (k == 0) check("latency", EW'(out_valid32), EW'(1));
    end
    check("throughput", EW'(cyc - c0), EW'(14));
    drain("directed");

    // Backpressure: hold the consumer off for three cycles while offering tags 1..5
    out_ready = 1'b0;
    t = 1;
    set_rand(32'(t));
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      acc = in_ready32;
      step();
      if (acc) begin t++; set_rand(32'(t)); end
    end
    check("bp_accepted", EW'(t - 1), EW'(2));
    @(negedge clk);
    check("bp_in_ready", EW'(in_ready32), EW'(0));
    step();
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_gapless", EW'(out_valid32), EW'(1));
      acc = in_ready32 && in_valid;
      step();
      if (acc) begin
        t++;
        if (t > 5) in_valid = 1'b0;
        else set_rand(32'(t));
      end
    end
    in_valid = 1'b0;
    drain("bp");

    // Flush with both entries full and a new input offered
    out_ready = 1'b0;
    send_rand(32'd20, 1'b0);
    send_rand(32'd21, 1'b0);
    set_rand(32'd22);
    in_valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid32", EW'(out_valid32), EW'(0));
    check("flush_valid64", EW'(out_valid64), EW'(0));
    check("flush_ready", EW'(in_ready32), EW'(1));
    step();
    out_ready = 1'b1;
    repeat (4) step();
    drain("flush");

    // Random stream with random consumer stalls and idle gaps
    for (int k = 0; k < 300; k++) begin
      send_rand(32'(1000 + k), 1'b1);
      if ($urandom_range(0, 4) == 0) step();
    end
    drain("random");

    // Reset in the middle of a stream
    out_ready = 1'b0;
    send_rand(32'd50, 1'b0);
    send_rand(32'd51, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out32", got32, '0);
    check("midrst_out64", got64, '0);
    check("midrst_ready", EW'(in_ready32), EW'(1));
    step();
    send_rand(32'd60, 1'b0);
    drain("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
